mem_wb_stage_elastic: RTL



---
 rtl/mem_wb_stage_elastic_pkg.sv | 23 ++
 rtl/mem_wb_stage_elastic_skid_buf.sv | 79 +++++++
 rtl/mem_wb_stage_elastic.sv | 93 +++++++++
 3 files changed

// File: rtl/mem_wb_stage_elastic_pkg.sv
// Shared types and constants for the elastic MEM->WB stage.
// Payload struct packs every per-instruction field so head and skid are single flop vectors.
package mem_wb_stage_elastic_pkg;

    localparam int N                 = 32;
    localparam int REG_FILE_ADDR_LEN = 5;

    typedef struct packed {
        logic                         wb_en;
        logic                         mem_r_en;
        logic [REG_FILE_ADDR_LEN-1:0] dest;
        logic [N-1:0]                 alu_res;
        logic [N-1:0]                 mem_read_val;
    } memwb_payload_t;

    // Encoding is {skid_v, head_v}; the two bits are read directly as valids.
    typedef enum logic [1:0] {
        SB_EMPTY = 2'b00,
        SB_ONE   = 2'b01,
        SB_TWO   = 2'b11
    } skid_state_e;

endpackage

// File: rtl/mem_wb_stage_elastic_skid_buf.sv
// memwb_skid_buf: generic 2-entry valid/ready skid buffer.
// in_ready is a flop bit (skid valid inverted), so no combinational path
// runs from out_ready back to in_ready. Flush clears valids only.
module memwb_skid_buf
    import mem_wb_stage_elastic_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         flush,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);

    skid_state_e  state_q, state_d;
    logic [W-1:0] head_q, head_d;
    logic [W-1:0] skid_q, skid_d;
    logic         in_fire, out_fire;

    assign in_ready  = ~state_q[1];
    assign out_valid = state_q[0];
    assign out_data  = head_q;
    assign in_fire   = in_valid & in_ready;
    assign out_fire  = out_valid & out_ready;

    // Next-state and payload steering; flush overrides the state only.
    always_comb begin
        state_d = state_q;
        head_d  = head_q;
        skid_d  = skid_q;
        case (state_q)
            SB_EMPTY: begin
                if (in_fire) begin
                    state_d = SB_ONE;
                    head_d  = in_data;
                end
            end
            SB_ONE: begin
                if (in_fire && out_fire) begin
                    head_d = in_data;
                end else if (in_fire) begin
                    state_d = SB_TWO;
                    skid_d  = in_data;
                end else if (out_fire) begin
                    state_d = SB_EMPTY;
                end
            end
            SB_TWO: begin
                if (out_fire) begin
                    state_d = SB_ONE;
                    head_d  = skid_q;
                end
            end
            default: state_d = SB_EMPTY;
        endcase
        if (flush) begin
            state_d = SB_EMPTY;
        end
    end

    // State and payload registers, asynchronously cleared.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= SB_EMPTY;
            head_q  <= '0;
            skid_q  <= '0;
        end else begin
            state_q <= state_d;
            head_q  <= head_d;
            skid_q  <= skid_d;
        end
    end

endmodule

// File: rtl/mem_wb_stage_elastic.sv
// mem_wb_stage_elastic: MEM->WB stage with valid/ready skid buffering,
// synchronous flush, write-back data mux and register-0 write drop.
// Optional stall counter enabled by defining MEMWB_PERF_EN.
module mem_wb_stage_elastic
    import mem_wb_stage_elastic_pkg::*;
#(
    parameter int DATA_W        = N,
    parameter int ADDR_W        = REG_FILE_ADDR_LEN,
    parameter bit ZERO_REG_DROP = 1'b1
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              wb_en_in,
    input  logic              mem_r_en_in,
    input  logic [ADDR_W-1:0] dest_in,
    input  logic [DATA_W-1:0] alu_res_in,
    input  logic [DATA_W-1:0] mem_read_val_in,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              wb_en,
    output logic              mem_r_en,
    output logic [ADDR_W-1:0] dest,
    output logic [DATA_W-1:0] alu_res,
    output logic [DATA_W-1:0] mem_read_val,
    output logic [DATA_W-1:0] wb_data,
    output logic              wb_we,
    output logic [31:0]       perf_stall_cnt
);

    localparam int PAY_W = $bits(memwb_payload_t);

    memwb_payload_t in_pl, out_pl;
    logic           zero_drop;

    assign in_pl.wb_en        = wb_en_in;
    assign in_pl.mem_r_en     = mem_r_en_in;
    assign in_pl.dest         = dest_in;
    assign in_pl.alu_res      = alu_res_in;
    assign in_pl.mem_read_val = mem_read_val_in;

    memwb_skid_buf #(.W(PAY_W)) u_skid (
        .clk       (clk),
        .rstn      (rstn),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_pl),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_pl)
    );

    assign wb_en        = out_pl.wb_en;
    assign mem_r_en     = out_pl.mem_r_en;
    assign dest         = out_pl.dest;
    assign alu_res      = out_pl.alu_res;
    assign mem_read_val = out_pl.mem_read_val;

    // Loads write back memory data, everything else the ALU result.
    assign wb_data   = out_pl.mem_r_en ? out_pl.mem_read_val : out_pl.alu_res;
    assign zero_drop = ZERO_REG_DROP && (out_pl.dest == '0);
    // A flushed head must not reach the register file even if accepted.
    assign wb_we     = out_valid & out_ready & out_pl.wb_en & ~zero_drop & ~flush;

`ifdef MEMWB_PERF_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;

    // Count cycles where a valid head is held back, saturating at all-ones.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (out_valid && !out_ready && !flush && (stall_cnt_q != 32'hFFFF_FFFF)) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
    end

    // Stall counter register, cleared only by reset.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            stall_cnt_q <= 32'd0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign perf_stall_cnt = stall_cnt_q;
`else
    assign perf_stall_cnt = 32'd0;
`endif

endmodule
